branch_stack: RTL
=================

Name: branch_stack

Overview:
- Branch-tag allocator and recovery controller for the 2-way R10K core. It hands each dispatched branch a BS_PTR slot and gives every dispatched instruction its B_MASK of outstanding older branches.
- It consumes the registered resolution outputs of the branch FU:
  - a correct prediction frees the slot and broadcasts a clear;
  - a misprediction frees the slot plus all younger dependent slots and issues a registered squash/redirect to fetch, RS, ROB and the FUs.

Parameters:
- NUM_BS, 4, number of branch-stack slots (B_MASK width).
- PTR_W, $clog2(NUM_BS), BS_PTR width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- disp_valid  in  2  lane instruction valid (lane 0 older)
- disp_is_br  in  2  lane instruction is a branch/jump needing a slot
- disp_stall  out  1  combinational; insufficient free slots or mispredict this cycle, so no lane dispatches
- disp_bs_ptr  out  2xPTR_W  slot allocated to each lane's branch
- disp_bmask  out  2xNUM_BS  B_MASK each lane instruction carries
- br_branch_resolved  in  1  branch FU resolution valid
- br_pred_wrong  in  1  resolved branch mispredicted
- br_bs_ptr  in  PTR_W  slot of resolving branch
- br_recov_NPC  in  64  correct next PC
- clr_en  out  1  registered; correct resolution broadcast
- clr_ptr  out  PTR_W  registered; slot to clear from all masks
- rec_en  out  1  registered; misprediction recovery
- rec_NPC  out  64  registered; redirect PC
- rec_squash_mask  out  NUM_BS  registered; slots whose dependents must be killed
- cur_bmask  out  NUM_BS  valid-slot vector (debug/ROB)

Behaviour:
- State per slot i:
  - valid[i]
  - dep_mask[i] = B_MASK of older outstanding branches at allocation time.
- Reset: valid, dep_mask and all registered outputs are 0; cur_bmask=0.
- Same-cycle resolution visibility:
  - base_mask = valid with bit br_bs_ptr cleared when a correct resolution arrives this cycle.
  - Freed slots are NOT reusable until the next cycle.
- Allocation request:
  - need = popcount(disp_valid & disp_is_br).
  - disp_stall = (need > free slot count) OR (br_branch_resolved AND br_pred_wrong).
  - On stall, nothing is allocated (all-or-nothing across both lanes).
- Slot choice:
  - The lowest-index free slot goes to the older requesting lane.
  - The next-lowest free slot goes to lane 1 if both lanes request.
- Masks carried by dispatched instructions:
  - Lane 0 disp_bmask = base_mask.
  - Lane 1 disp_bmask = base_mask plus lane 0's new bit if lane 0 is a branch.
  - A branch's own bit is never in its own mask.
- On allocation:
  - valid[slot] <= 1.
  - dep_mask[slot] <= that lane's disp_bmask.
- Correct resolution (resolved AND NOT pred_wrong):
  - valid[ptr] <= 0.
  - Bit ptr is cleared in every dep_mask.
  - Next cycle: clr_en=1, clr_ptr=ptr.
- Misprediction (resolved AND pred_wrong):
  - kill = (1<<ptr) | {j : valid[j] AND dep_mask[j][ptr]}.
  - valid[kill] <= 0.
  - Next cycle: rec_en=1, rec_NPC=br_recov_NPC, rec_squash_mask=kill.
  - Same-cycle allocations are suppressed (they are wrong-path).
- clr_en and rec_en are mutually exclusive; each is a 1-cycle pulse, and otherwise 0 with payload held at 0.
- A resolution naming an invalid slot is ignored: no state change, no pulse. Simulation asserts an error.
- Reset mid-recovery: reset wins, all state and outputs return to 0 next cycle.
- Back-to-back resolutions in consecutive cycles are each handled independently.

Decomposition:
- Shared package:
  - `NUM_BRANCH_STACK
  - BS_PTR and B_MASK typedefs
  - BS_RECOV_t struct {rec_en, rec_NPC, rec_squash_mask}
- Sub-module bs_alloc_sel: combinational two-lowest-free-slot selector from a free vector, with found flags.

Test Plan:
- Reset then lanes {br, br} -> disp_bs_ptr {0,1}; disp_bmask {0000, 0001}; next cycle cur_bmask=0011.
- Slots 0-2 valid, request 2 branches -> disp_stall=1, no state change; single branch request -> gets ptr 3; cur_bmask=1111.
- Slots 0,1 valid (1 depends on 0), correct resolve ptr 0 -> next cycle clr_en=1, clr_ptr=0; dep_mask[1]=0000; cur_bmask=0010.
- Slots 0,1,2 chained, mispredict ptr 1 with NPC 0x1000 -> next cycle rec_en=1, rec_NPC=0x1000, rec_squash_mask=0110; cur_bmask=0001.
- Mispredict ptr 0 with lane 0 branch dispatching same cycle -> disp_stall=1, no allocation, rec_squash_mask covers only pre-existing dependents.
- Correct resolve ptr 2 while lane 0 non-branch dispatches with slots 0,2 valid -> disp_bmask[0]=0001, disp_stall=0.

Source files
------------

// File: rtl/branch_stack_pkg.sv
// Shared types for the branch stack: slot pointer, branch mask, recovery bundle.
`ifndef NUM_BRANCH_STACK
`define NUM_BRANCH_STACK 4
`endif

package branch_stack_pkg;

    localparam int unsigned NUM_BS = `NUM_BRANCH_STACK;
    localparam int unsigned PTR_W  = $clog2(NUM_BS);

    typedef logic [PTR_W-1:0]  BS_PTR;
    typedef logic [NUM_BS-1:0] B_MASK;
    typedef logic [PTR_W:0]    BS_CNT;

    typedef struct packed {
        logic        rec_en;
        logic [63:0] rec_NPC;
        B_MASK       rec_squash_mask;
    } BS_RECOV_t;

    // Number of set bits in a slot vector.
    function automatic BS_CNT bs_popcount(input B_MASK v);
        BS_CNT cnt;
        cnt = '0;
        for (int i = 0; i < NUM_BS; i++) begin
            cnt = cnt + BS_CNT'(v[i]);
        end
        return cnt;
    endfunction

    // One-hot slot vector for a pointer.
    function automatic B_MASK bs_onehot(input BS_PTR p);
        return B_MASK'(1) << p;
    endfunction

endpackage

// File: rtl/branch_stack_if.sv
// Dispatch, resolution and recovery signals between the core and the branch stack.
interface branch_stack_if;
    import branch_stack_pkg::*;

    // Dispatch side (lane 0 is older)
    logic [1:0]  disp_valid;
    logic [1:0]  disp_is_br;
    logic        disp_stall;
    BS_PTR [1:0] disp_bs_ptr;
    B_MASK [1:0] disp_bmask;

    // Branch FU resolution
    logic        br_branch_resolved;
    logic        br_pred_wrong;
    BS_PTR       br_bs_ptr;
    logic [63:0] br_recov_NPC;

    // Clear / recovery broadcasts
    logic        clr_en;
    BS_PTR       clr_ptr;
    logic        rec_en;
    logic [63:0] rec_NPC;
    B_MASK       rec_squash_mask;
    B_MASK       cur_bmask;

    modport master (
        output disp_valid, disp_is_br,
        output br_branch_resolved, br_pred_wrong, br_bs_ptr, br_recov_NPC,
        input  disp_stall, disp_bs_ptr, disp_bmask,
        input  clr_en, clr_ptr, rec_en, rec_NPC, rec_squash_mask, cur_bmask
    );

    modport slave (
        input  disp_valid, disp_is_br,
        input  br_branch_resolved, br_pred_wrong, br_bs_ptr, br_recov_NPC,
        output disp_stall, disp_bs_ptr, disp_bmask,
        output clr_en, clr_ptr, rec_en, rec_NPC, rec_squash_mask, cur_bmask
    );

endinterface

// File: rtl/bs_alloc_sel.sv
// Picks the two lowest-index free slots from a free vector.
module bs_alloc_sel
    import branch_stack_pkg::*;
(
    input  B_MASK free,
    output BS_PTR first_ptr,
    output logic  first_found,
    output BS_PTR second_ptr,
    output logic  second_found
);

    // Ascending scan: first hit is the lowest free slot, second hit the next one.
    always_comb begin
        first_ptr    = '0;
        first_found  = 1'b0;
        second_ptr   = '0;
        second_found = 1'b0;
        for (int i = 0; i < NUM_BS; i++) begin
            if (free[i]) begin
                if (!first_found) begin
                    first_found = 1'b1;
                    first_ptr   = BS_PTR'(i);
                end else if (!second_found) begin
                    second_found = 1'b1;
                    second_ptr   = BS_PTR'(i);
                end
            end
        end
    end

endmodule

// File: rtl/branch_stack.sv
// Branch-tag allocator and recovery controller for the 2-way dispatch core.
module branch_stack
    import branch_stack_pkg::*;
(
    input logic           clk,
    input logic           reset,
    branch_stack_if.slave bus
);

    // Slot state
    B_MASK               valid_q, valid_d;
    B_MASK [NUM_BS-1:0]  dep_q, dep_d;

    // Registered broadcasts
    logic      clr_en_q, clr_en_d;
    BS_PTR     clr_ptr_q, clr_ptr_d;
    BS_RECOV_t recov_q, recov_d;

    // Resolution decode
    logic  res_hit;
    logic  res_ok;
    logic  res_bad;
    B_MASK res_oh;
    B_MASK base_mask;
    B_MASK kill;

    // Allocation
    logic [1:0]  req;
    BS_CNT       need;
    logic        cap_stall;
    logic        stall;
    logic        alloc;
    BS_PTR       first_ptr, second_ptr;
    logic        first_found, second_found;
    BS_PTR [1:0] lane_ptr;
    B_MASK [1:0] lane_mask;

    // A resolution only acts when it names an outstanding slot.
    always_comb begin
        res_oh    = bs_onehot(bus.br_bs_ptr);
        res_hit   = bus.br_branch_resolved && valid_q[bus.br_bs_ptr];
        res_ok    = res_hit && !bus.br_pred_wrong;
        res_bad   = res_hit && bus.br_pred_wrong;
        // A branch resolving correctly this cycle is already gone from new masks.
        base_mask = res_ok ? (valid_q & ~res_oh) : valid_q;
    end

    // Kill set: the mispredicted slot plus every live slot that depends on it.
    always_comb begin
        kill = res_oh;
        for (int j = 0; j < NUM_BS; j++) begin
            if (valid_q[j] && dep_q[j][bus.br_bs_ptr]) begin
                kill[j] = 1'b1;
            end
        end
    end

    // Free slots come from last cycle's valid so a slot freed now is not reused now.
    bs_alloc_sel u_alloc_sel (
        .free         (~valid_q),
        .first_ptr    (first_ptr),
        .first_found  (first_found),
        .second_ptr   (second_ptr),
        .second_found (second_found)
    );

    // All-or-nothing stall decision and per-lane slot/mask assignment.
    always_comb begin
        req  = bus.disp_valid & bus.disp_is_br;
        need = bs_popcount(B_MASK'(req));
        // Same as need > free count, using the selector's found flags.
        cap_stall = ((need == BS_CNT'(2)) && !second_found) ||
                    ((need == BS_CNT'(1)) && !first_found);
        // Any mispredict stalls dispatch, the same-cycle lanes are wrong-path.
        stall = cap_stall || (bus.br_branch_resolved && bus.br_pred_wrong);
        alloc = !stall && (req != 2'b00);

        lane_ptr[0] = req[0] ? first_ptr : '0;
        lane_ptr[1] = '0;
        if (req[1]) begin
            lane_ptr[1] = req[0] ? second_ptr : first_ptr;
        end

        lane_mask[0] = base_mask;
        lane_mask[1] = base_mask | (req[0] ? bs_onehot(first_ptr) : '0);
    end

    // Slot state update: resolve first, then record new allocations.
    always_comb begin
        valid_d = valid_q;
        dep_d   = dep_q;

        if (res_ok) begin
            valid_d[bus.br_bs_ptr] = 1'b0;
            for (int j = 0; j < NUM_BS; j++) begin
                dep_d[j][bus.br_bs_ptr] = 1'b0;
            end
        end

        if (res_bad) begin
            valid_d = valid_d & ~kill;
        end

        if (alloc) begin
            for (int l = 0; l < 2; l++) begin
                if (req[l]) begin
                    valid_d[lane_ptr[l]] = 1'b1;
                    dep_d[lane_ptr[l]]   = lane_mask[l];
                end
            end
        end
    end

    // Next values of the one-cycle clear / recovery pulses; payload is zero when idle.
    always_comb begin
        clr_en_d  = res_ok;
        clr_ptr_d = res_ok ? bus.br_bs_ptr : '0;
        recov_d   = '0;
        if (res_bad) begin
            recov_d.rec_en          = 1'b1;
            recov_d.rec_NPC         = bus.br_recov_NPC;
            recov_d.rec_squash_mask = kill;
        end
    end

    // State and broadcast registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= '0;
            dep_q     <= '0;
            clr_en_q  <= 1'b0;
            clr_ptr_q <= '0;
            recov_q   <= '0;
        end else begin
            valid_q   <= valid_d;
            dep_q     <= dep_d;
            clr_en_q  <= clr_en_d;
            clr_ptr_q <= clr_ptr_d;
            recov_q   <= recov_d;
        end
    end

    assign bus.disp_stall      = stall;
    assign bus.disp_bs_ptr     = lane_ptr;
    assign bus.disp_bmask      = lane_mask;
    assign bus.clr_en          = clr_en_q;
    assign bus.clr_ptr         = clr_ptr_q;
    assign bus.rec_en          = recov_q.rec_en;
    assign bus.rec_NPC         = recov_q.rec_NPC;
    assign bus.rec_squash_mask = recov_q.rec_squash_mask;
    assign bus.cur_bmask       = valid_q;

`ifndef SYNTHESIS
    // Resolving a slot that is not outstanding points at an upstream bug.
    a_res_valid_slot : assert property (
        @(posedge clk) disable iff (reset)
        bus.br_branch_resolved |-> valid_q[bus.br_bs_ptr]
    ) else $error("branch_stack: resolution names invalid slot %0d", bus.br_bs_ptr);
`endif

endmodule
